// File: rtl/gea1_pkg.sv
// Shared definitions for the gea1 input-conditioning cells: filter FSM
// encoding and the legal synchronizer depth range.
package gea1_pkg;

  typedef enum logic {
    MATCH = 1'b0,
    QUAL  = 1'b1
  } filt_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_chain_gea1.sv
// Multi-flop level synchronizer for an asynchronous input; q is the last stage.
// Reused for other async inputs, so it carries no filter logic.
module sync_chain_gea1 #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/filt_sync_gea1.sv
// Synchronizes an async level and accepts a new level only after it has been
// stable for max(thresh,1) cycles; emits registered rise/fall pulses and a sticky event.
module filt_sync_gea1
  import gea1_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_W      = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              en,
  input  logic [FILT_W-1:0] thresh,
  input  logic              evt_clr,
  output logic              y,
  output logic              rise,
  output logic              fall,
  output logic              evt
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("filt_sync_gea1: SYNC_STAGES out of range");
    end
  endgenerate

  localparam logic [FILT_W:0] ONE = (FILT_W+1)'(1);

  logic              s;
  filt_state_t       state;
  logic [FILT_W-1:0] cnt;
  logic [FILT_W:0]   eff_thresh;
  logic [FILT_W:0]   cnt_inc;

  sync_chain_gea1 #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RST_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a),
    .q     (s)
  );

  // One extra bit so cnt+1 never wraps before the compare.
  assign eff_thresh = (thresh == '0) ? ONE : {1'b0, thresh};
  assign cnt_inc    = {1'b0, cnt} + ONE;

  // cnt is held at 0 in MATCH, so cnt_inc == 1 covers the first mismatch edge too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MATCH;
      cnt   <= '0;
      y     <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!en) begin
        state <= MATCH;
        cnt   <= '0;
        y     <= s;
        rise  <= s & ~y;
        fall  <= ~s & y;
      end else if (s == y) begin
        state <= MATCH;
        cnt   <= '0;
      end else if (cnt_inc >= eff_thresh) begin
        state <= MATCH;
        cnt   <= '0;
        y     <= ~y;
        rise  <= ~y;
        fall  <= y;
      end else begin
        state <= QUAL;
        cnt   <= cnt_inc[FILT_W-1:0];
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt <= 1'b0;
    end else if (rise | fall) begin
      evt <= 1'b1;
    end else if (evt_clr) begin
      evt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filt_sync_gea1.sv
// Directed bench for filt_sync_gea1 (N=2, FILT_W=4, RST_VAL=0) with
// hand-computed edge counts for qualify, glitch, bypass, sticky and reset cases.
module tb_filt_sync_gea1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a;
  logic       en;
  logic [3:0] thresh;
  logic       evt_clr;
  logic       y, rise, fall, evt;

  int n_checks = 0;
  int n_fails  = 0;

  filt_sync_gea1 #(
    .SYNC_STAGES (2),
    .FILT_W      (4),
    .RST_VAL     (1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .en      (en),
    .thresh  (thresh),
    .evt_clr (evt_clr),
    .y       (y),
    .rise    (rise),
    .fall    (fall),
    .evt     (evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toggle a (width>0), restore it before edge width+1, run total edges and
  // record the first rise/fall edge index (0 = none) and pulse counts.
  task automatic drive_pulse(input int width, input int total,
                             output int rcyc, output int fcyc,
                             output int nr, output int nf, output int nboth);
    rcyc = 0; fcyc = 0; nr = 0; nf = 0; nboth = 0;
    if (width > 0) a = ~a;
    for (int k = 1; k <= total; k++) begin
      if (width > 0 && k == width + 1) a = ~a;
      tick();
      if (rise) begin nr++; if (rcyc == 0) rcyc = k; end
      if (fall) begin nf++; if (fcyc == 0) fcyc = k; end
      if (rise && fall) nboth++;
    end
  endtask

  int rc, fc, nr, nf, nb;

  initial begin
    a = 1'b1; en = 1'b1; thresh = 4'd4; evt_clr = 1'b0; rst_n = 1'b0;

    // Reset held with a=1: outputs stay at reset values.
    repeat (3) tick();
    check("rst_y", y, 0);
    check("rst_pulses", {rise, fall}, 0);
    check("rst_evt", evt, 0);

    // Release; a=1 already stable -> y after edge 6, evt after edge 7.
    rst_n = 1'b1;
    repeat (5) tick();
    check("qual_y_edge5", y, 0);
    tick();
    check("qual_y_edge6", y, 1);
    check("qual_rise_edge6", rise, 1);
    check("qual_evt_edge6", evt, 0);
    tick();
    check("qual_rise_edge7", rise, 0);
    check("qual_evt_edge7", evt, 1);

    // evt_clr alone clears at the next edge.
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    check("evtclr_alone", evt, 0);

    // 3-cycle glitch with thresh=4 is rejected.
    drive_pulse(3, 15, rc, fc, nr, nf, nb);
    check("glitch3_pulses", nr + nf, 0);
    check("glitch3_y", y, 1);
    check("glitch3_evt", evt, 0);

    // 4-cycle pulse from y=1: fall at edge 6, rise back 4 edges later.
    drive_pulse(4, 16, rc, fc, nr, nf, nb);
    check("pulse4_fall_edge", fc, 6);
    check("pulse4_rise_edge", rc, 10);
    check("pulse4_counts", nr * 10 + nf, 11);
    check("pulse4_overlap", nb, 0);

    // thresh=0 and thresh=1 both flip at edge 3.
    thresh = 4'd0;
    drive_pulse(99, 6, rc, fc, nr, nf, nb);
    check("thr0_fall_edge", fc, 3);
    thresh = 4'd1;
    drive_pulse(99, 6, rc, fc, nr, nf, nb);
    check("thr1_rise_edge", rc, 3);

    // Bypass with thresh=15: y follows after edge 3.
    en = 1'b0; thresh = 4'd15;
    drive_pulse(99, 6, rc, fc, nr, nf, nb);
    check("byp_fall_edge", fc, 3);
    check("byp_y_low", y, 0);
    drive_pulse(99, 6, rc, fc, nr, nf, nb);
    check("byp_rise_edge", rc, 3);
    en = 1'b1;

    // Clear evt, then hold evt_clr across the edge that sets it: set wins.
    evt_clr = 1'b1;
    tick();
    evt_clr = 1'b0;
    check("evtclr_pre", evt, 0);
    thresh = 4'd1;
    a = 1'b0;
    repeat (3) tick();
    check("setclr_fall", fall, 1);
    evt_clr = 1'b1;
    tick();
    check("setclr_evt_edge4", evt, 1);
    evt_clr = 1'b0;
    tick();
    check("setclr_evt_edge5", evt, 1);

    // Async reset mid-qualify (counter=2 after edge 4), then restart.
    thresh = 4'd4;
    a = 1'b1;
    repeat (4) tick();
    check("midq_y_before", y, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_evt", evt, 0);
    check("async_y_pulses", {y, rise, fall}, 0);
    #2;
    rst_n = 1'b1;
    drive_pulse(0, 8, rc, fc, nr, nf, nb);
    check("restart_rise_edge", rc, 6);
    check("restart_y", y, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
